// File: rtl/tc_to_sm_encoder.sv
// Two's-complement Q21.10 to sign-magnitude Q21.10 encoder, 2-stage valid/ready pipeline.
// Define SAT_COUNT_EN to add the saturating sat_count event counter port.
module tc_to_sm_encoder #(
    parameter int W         = 32,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_sat
`ifdef SAT_COUNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_count
`endif
);

    if (W < 12) begin : g_bad_w
        $error("tc_to_sm_encoder: W must be at least 12");
    end
    if (SAT_CNT_W < 1) begin : g_bad_cnt
        $error("tc_to_sm_encoder: SAT_CNT_W must be at least 1");
    end

    localparam logic [W:0] MAX_POS = {2'b00, {(W-1){1'b1}}};

    logic         s1_valid;
    logic         s1_neg;
    logic [W:0]   s1_mag;
    logic         s2_valid;
    logic         adv1;
    logic [W:0]   ext;
    logic [W:0]   mag_next;
    logic         sat_next;
    logic         zero_next;
    logic [W-1:0] data_next;

    assign adv1      = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || adv1;
    assign out_valid = s2_valid;

    // One extra bit keeps the magnitude of the most negative input from wrapping.
    assign ext      = {in_data[W-1], in_data};
    assign mag_next = in_data[W-1] ? (~ext + (W+1)'(1)) : ext;

    assign sat_next  = s1_mag > MAX_POS;
    assign zero_next = s1_mag == '0;

    always_comb begin
        data_next = {s1_neg, s1_mag[W-2:0]};
        if (sat_next) begin
            data_next = '1;
        end else if (zero_next) begin
            data_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_mag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_neg <= in_data[W-1];
                s1_mag <= mag_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (adv1) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_next;
                out_sat  <= sat_next;
            end
        end
    end

`ifdef SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end
`endif

endmodule
